// File: rtl/memory_access.sv
// memory_access: pipeline memory stage, single-outstanding data bus, load extension. Optional MEM_MISALIGN_CHECK_EN.
// Latency: non-memory op 1 cycle to out_valid; memory op out_valid the cycle after dresp_ok.
// Backpressure: in_ready low while a bus request is in flight or an unaccepted result is held.
module memory_access #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_alu_out,
  input  logic [WIDTH-1:0] in_wdata,
  input  logic             in_memread,
  input  logic             in_memwrite,
  input  logic [1:0]       in_size,
  input  logic             in_unsigned,
  output logic             dreq_valid,
  output logic [WIDTH-1:0] dreq_addr,
  output logic [1:0]       dreq_size,
  output logic [7:0]       dreq_strobe,
  output logic [WIDTH-1:0] dreq_data,
  input  logic             dresp_ok,
  input  logic [WIDTH-1:0] dresp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_result,
  output logic             out_misalign
);
  typedef logic [WIDTH-1:0] word_t;
  typedef enum logic [1:0] {IDLE, BUS, HOLD} state_t;

  state_t     state;
  logic       ld_op;
  logic       ld_unsigned;
  logic       accept;
  logic       mem_op;
  logic       cap_mis;
  logic       sx;
  logic [7:0] cap_strobe;
  word_t      cap_data;
  word_t      lane_data;
  word_t      ld_ext;

  assign in_ready = (state != BUS) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign mem_op   = in_memread || in_memwrite;

  // Lane placement uses addr[2:0] only; strobe bits shifted past lane 7 fall off.
  always_comb begin
    cap_data = in_wdata << {in_alu_out[2:0], 3'b000};
    case (in_size)
      2'd0:    cap_strobe = 8'h01 << in_alu_out[2:0];
      2'd1:    cap_strobe = 8'h03 << in_alu_out[2:0];
      2'd2:    cap_strobe = 8'h0f << in_alu_out[2:0];
      default: begin
        cap_strobe = 8'hff;
        cap_data   = in_wdata;
      end
    endcase
    if (!in_memwrite) cap_strobe = 8'h00;
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    case (in_size)
      2'd1:    cap_mis = in_alu_out[0];
      2'd2:    cap_mis = |in_alu_out[1:0];
      2'd3:    cap_mis = |in_alu_out[2:0];
      default: cap_mis = 1'b0;
    endcase
    cap_mis = cap_mis && mem_op;
  end
`else
  assign cap_mis      = 1'b0;
  assign out_misalign = 1'b0;
`endif

  assign lane_data = dresp_data >> {dreq_addr[2:0], 3'b000};
  assign sx        = !ld_unsigned;

  always_comb begin
    case (dreq_size)
      2'd0:    ld_ext = {{(WIDTH-8){sx & lane_data[7]}}, lane_data[7:0]};
      2'd1:    ld_ext = {{(WIDTH-16){sx & lane_data[15]}}, lane_data[15:0]};
      2'd2:    ld_ext = {{(WIDTH-32){sx & lane_data[31]}}, lane_data[31:0]};
      default: ld_ext = lane_data;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_result  <= '0;
      dreq_valid  <= 1'b0;
      dreq_addr   <= '0;
      dreq_size   <= '0;
      dreq_strobe <= '0;
      dreq_data   <= '0;
      ld_op       <= 1'b0;
      ld_unsigned <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      out_misalign <= 1'b0;
`endif
    end else begin
      case (state)
        BUS: begin
          if (dresp_ok) begin
            dreq_valid <= 1'b0;
            out_valid  <= 1'b1;
            out_result <= ld_op ? ld_ext : dreq_addr;
            state      <= HOLD;
          end
        end
        default: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
          if (out_ready) state <= IDLE;
          if (accept) begin
            out_pc      <= in_pc;
            dreq_addr   <= in_alu_out;
            dreq_size   <= in_size;
            dreq_strobe <= cap_strobe;
            dreq_data   <= cap_data;
            ld_op       <= in_memread;
            ld_unsigned <= in_unsigned;
`ifdef MEM_MISALIGN_CHECK_EN
            out_misalign <= cap_mis;
`endif
            if (mem_op && !cap_mis) begin
              dreq_valid <= 1'b1;
              state      <= BUS;
            end else begin
              out_result <= in_alu_out;
              out_valid  <= 1'b1;
              state      <= IDLE;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// Scoreboarded bench for memory_access: random bus latency, random writeback stalls, directed corner cases.
module tb_memory_access;
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [63:0] in_pc = '0, in_alu_out = '0, in_wdata = '0;
  logic        in_memread = 1'b0, in_memwrite = 1'b0, in_unsigned = 1'b0;
  logic [1:0]  in_size = '0;
  logic        dreq_valid;
  logic [63:0] dreq_addr, dreq_data;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_ok = 1'b0;
  logic [63:0] dresp_data = '0;
  logic        out_valid, out_ready = 1'b0, out_misalign;
  logic [63:0] out_pc, out_result;

  always #5 clk = ~clk;

  memory_access #(.WIDTH(64)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_alu_out(in_alu_out),
    .in_wdata(in_wdata), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_size(in_size), .in_unsigned(in_unsigned),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_ok(dresp_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_result(out_result), .out_misalign(out_misalign)
  );

  typedef struct {logic [63:0] pc; logic [63:0] result; logic mis;} out_t;
  typedef struct {logic [63:0] addr; logic [63:0] data; logic [1:0] size; logic [7:0] strobe; logic [63:0] rdata;} req_t;

  out_t exp_q[$];
  req_t req_q[$];
  int   n_chk = 0, n_fail = 0;
  int   force_wait = -1;
  int   ordy_mode = 2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: condition occurred, required it not to", name);
  endtask

  function automatic logic [63:0] lane_mask(input logic [7:0] s);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  // Load value: nb bytes starting at lane a, then extended to 64 bits.
  function automatic logic [63:0] ld_model(input logic [63:0] d, input int a, input int nb, input logic uns);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = d[8*((a + k) % 8) +: 8];
    if (!uns && nb < 8 && v[8*nb-1])
      for (int k = nb; k < 8; k++) v[8*k +: 8] = 8'hff;
    return v;
  endfunction

  task automatic issue(input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] wd,
                       input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [63:0] rdata, output int tries, output logic ov_at_acc);
    out_t e;
    req_t r;
    int   nb, ln;
    logic mis;
    nb  = 1 << sz;
    mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = (rd || wr) && ((alu & 64'(nb - 1)) != 64'd0);
`endif
    e.pc  = pc;
    e.mis = mis;
    if (!(rd || wr) || mis) begin
      e.result = alu;
    end else begin
      r.addr = alu; r.size = sz; r.rdata = rdata; r.strobe = '0; r.data = '0;
      if (wr)
        for (int k = 0; k < nb; k++) begin
          ln = (int'(alu[2:0]) + k) % 8;
          r.strobe[ln]     = 1'b1;
          r.data[8*ln +: 8] = wd[8*k +: 8];
        end
      req_q.push_back(r);
      e.result = wr ? alu : ld_model(rdata, int'(alu[2:0]), nb, uns);
    end
    exp_q.push_back(e);
    tries = 0;
    @(negedge clk);
    in_valid = 1'b1; in_pc = pc; in_alu_out = alu; in_wdata = wd;
    in_memread = rd; in_memwrite = wr; in_size = sz; in_unsigned = uns;
    forever begin
      #4;
      tries++;
      if (in_ready) break;
      if (tries > 200) begin fail("accept_timeout"); break; end
      @(negedge clk);
    end
    ov_at_acc = out_valid;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail("drain_timeout");
  endtask

  // Bus slave: checks request fields every cycle they are presented, answers after a random wait.
  initial begin : responder
    int   wait_cnt;
    bit   new_req;
    req_t r;
    new_req = 1'b1; wait_cnt = 0;
    r = '{default: '0};
    forever begin
      @(negedge clk);
      dresp_ok = 1'b0;
      if (!resetn) begin
        new_req = 1'b1;
      end else if (dreq_valid) begin
        if (new_req) begin
          if (req_q.size() == 0) begin fail("unexpected_dreq"); r = '{default: '0}; end
          else r = req_q.pop_front();
          wait_cnt = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
          new_req  = 1'b0;
        end
        chk("dreq_addr", dreq_addr, r.addr);
        chk("dreq_size", 64'(dreq_size), 64'(r.size));
        chk("dreq_strobe", 64'(dreq_strobe), 64'(r.strobe));
        chk("dreq_data", dreq_data & lane_mask(r.strobe), r.data & lane_mask(r.strobe));
        if (wait_cnt == 0) begin
          dresp_ok   = 1'b1;
          dresp_data = r.rdata;
          new_req    = 1'b1;
        end else wait_cnt--;
      end else if ($urandom_range(0, 3) == 0) begin
        dresp_ok   = 1'b1;
        dresp_data = {$urandom, $urandom};
      end
    end
  end

  initial begin : wb_ready
    forever begin
      @(negedge clk);
      out_ready = (ordy_mode == 2) ? ($urandom_range(0, 2) != 0) : (ordy_mode == 1);
    end
  end

  initial begin : monitor
    bit   held;
    out_t prev, e;
    held = 1'b0;
    prev = '{default: '0};
    forever begin
      @(negedge clk);
      #3;
      if (!resetn || !out_valid) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_pc", out_pc, prev.pc);
          chk("hold_result", out_result, prev.result);
          chk("hold_misalign", 64'(out_misalign), 64'(prev.mis));
        end
        if (out_ready) begin
          if (exp_q.size() == 0) fail("unexpected_out");
          else begin
            e = exp_q.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_result", out_result, e.result);
            chk("out_misalign", 64'(out_misalign), 64'(e.mis));
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          prev.pc = out_pc; prev.result = out_result; prev.mis = out_misalign;
        end
      end
    end
  end

  initial begin : main
    int          tries;
    logic        ova;
    int          kind;
    logic [1:0]  sz;
    logic [63:0] a;

    #2 resetn = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dreq_valid", 64'(dreq_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_misalign", 64'(out_misalign), 64'd0);
    chk("rst_dreq_addr", dreq_addr, 64'd0);
    chk("rst_dreq_strobe", 64'(dreq_strobe), 64'd0);
    chk("rst_dreq_data", dreq_data, 64'd0);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;

    // Non-memory op: result visible the cycle after capture, no bus request.
    issue(64'h8000_0000, 64'h1234, '0, 1'b0, 1'b0, 2'd3, 1'b0, '0, tries, ova);
    @(negedge clk); #3;
    chk("nonmem_lat_valid", 64'(out_valid), 64'd1);
    chk("nonmem_result", out_result, 64'h1234);
    chk("nonmem_no_dreq", 64'(dreq_valid), 64'd0);
    drain();

    // Signed byte load, zero-wait bus, then held 4 cycles by writeback.
    force_wait = 0; ordy_mode = 0;
    issue(64'h100, 64'h1003, '0, 1'b1, 1'b0, 2'd0, 1'b0, 64'h0000_0000_8000_0000, tries, ova);
    @(negedge clk); #3;
    chk("ld_lat_dreq", 64'(dreq_valid), 64'd1);
    @(negedge clk); #3;
    chk("ld_lat_out", 64'(out_valid), 64'd1);
    chk("ld_signed_byte", out_result, 64'hFFFF_FFFF_FFFF_FF80);
    for (int i = 0; i < 4; i++) begin
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (i < 3) begin @(negedge clk); #3; end
    end
    ordy_mode = 1;
    issue(64'h104, 64'h1003, '0, 1'b1, 1'b0, 2'd0, 1'b1, 64'h0000_0000_8000_0000, tries, ova);
    chk("b2b_accept_tries", 64'(tries), 64'd1);
    chk("b2b_accept_with_out", 64'(ova), 64'd1);
    drain();

    // Word store with three wait cycles; request must stay up the whole time.
    ordy_mode = 2; force_wait = 3;
    issue(64'h200, 64'h2004, 64'hDEAD_BEEF, 1'b0, 1'b1, 2'd2, 1'b0, '0, tries, ova);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #3;
      chk("st_dreq_held", 64'(dreq_valid), 64'd1);
    end
    chk("st_strobe", 64'(dreq_strobe), 64'hF0);
    a = dreq_data;
    chk("st_data_hi", a >> 32, 64'hDEAD_BEEF);
    drain();

    // Reset while the bus request is outstanding.
    force_wait = 20;
    issue(64'h300, 64'h4008, '0, 1'b1, 1'b0, 2'd3, 1'b0, 64'h55, tries, ova);
    @(negedge clk); #3;
    chk("rstbus_dreq_before", 64'(dreq_valid), 64'd1);
    resetn = 1'b0;
    #1;
    chk("rstbus_dreq_drop", 64'(dreq_valid), 64'd0);
    chk("rstbus_out_drop", 64'(out_valid), 64'd0);
    exp_q.delete();
    req_q.delete();
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    force_wait = -1;
    issue(64'h304, 64'hABCD, '0, 1'b0, 1'b0, 2'd0, 1'b0, '0, tries, ova);
    chk("rstbus_fresh_accept", 64'(tries), 64'd1);
    drain();

`ifdef MEM_MISALIGN_CHECK_EN
    issue(64'h400, 64'h3001, '0, 1'b1, 1'b0, 2'd1, 1'b0, '0, tries, ova);
    @(negedge clk); #3;
    chk("mis_valid", 64'(out_valid), 64'd1);
    chk("mis_flag", 64'(out_misalign), 64'd1);
    chk("mis_result", out_result, 64'h3001);
    chk("mis_no_dreq", 64'(dreq_valid), 64'd0);
    drain();
`endif

    // Random mix with random bus latency and writeback stalls.
    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom_range(0, 2));
      sz   = 2'($urandom_range(0, 3));
      a    = {$urandom, $urandom};
      a    = a & ~((64'd1 << sz) - 64'd1);
      issue({$urandom, $urandom}, a, {$urandom, $urandom}, kind == 1, kind == 2, sz,
            1'($urandom_range(0, 1)), {$urandom, $urandom}, tries, ova);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
